// File: rtl/psum_accum_ctrl_if.sv
// Control, OFIFO and PSUM SRAM signal bundle for the partial-sum accumulation controller.
// master = controller view; slave = environment (OFIFO, SRAM, sequencer) view.
interface psum_accum_ctrl_if #(
    parameter int psum_bw = 16,
    parameter int col     = 8,
    parameter int addr_bw = 11
);
    logic                      start;
    logic [1:0]                mode;
    logic [addr_bw-1:0]        base_addr;
    logic [addr_bw-1:0]        length;
    logic                      busy;
    logic                      done;

    logic                      ofifo_valid;
    logic [col*psum_bw-1:0]    ofifo_out;
    logic                      ofifo_rd;

    logic                      sram_cen;
    logic                      sram_wen;
    logic [addr_bw-1:0]        sram_addr;
    logic [col*psum_bw-1:0]    sram_d;
    logic [col*psum_bw-1:0]    sram_q;

    modport master (
        input  start, mode, base_addr, length, ofifo_valid, ofifo_out, sram_q,
        output busy, done, ofifo_rd, sram_cen, sram_wen, sram_addr, sram_d
    );

    modport slave (
        output start, mode, base_addr, length, ofifo_valid, ofifo_out, sram_q,
        input  busy, done, ofifo_rd, sram_cen, sram_wen, sram_addr, sram_d
    );
endinterface

// File: rtl/psum_accum_ctrl.sv
// Purpose: per-word passthrough / accumulate / ReLU of OFIFO partial sums into PSUM SRAM.
// Latency: 2 cycles/word passthrough, 3 cycles/word accumulate or ReLU, plus one DONE cycle.
// Backpressure: stalls in FETCH while the OFIFO is empty; start is ignored while busy.
module psum_accum_ctrl #(
    parameter int psum_bw = 16,
    parameter int col     = 8,
    parameter int addr_bw = 11
) (
    input  logic                 clk,
    input  logic                 reset,
    psum_accum_ctrl_if.master    bus
);
    localparam int word_bw = col * psum_bw;

    typedef enum logic [2:0] {IDLE, FETCH, WAIT, WRITE, DONE} state_t;

    typedef struct packed {
        logic [1:0]         mode;
        logic [addr_bw-1:0] length;
    } cfg_t;

    state_t               state;
    state_t               state_nxt;
    cfg_t                 cfg;
    logic [addr_bw-1:0]   ptr;
    logic [addr_bw-1:0]   cnt;
    logic [addr_bw-1:0]   cnt_inc;
    logic [word_bw-1:0]   ofifo_dat;
    logic [word_bw-1:0]   sram_dat;
    logic [word_bw-1:0]   result;
    logic                 pop;
    logic                 rd_issue;
    logic                 wr_issue;
    logic                 relu;
    logic                 pass;

    assign relu    = cfg.mode[1];
    assign pass    = (cfg.mode == 2'b00);
    assign cnt_inc = cnt + 1'b1;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        rd_issue  = 1'b0;
        wr_issue  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nxt = (bus.length == '0) ? DONE : FETCH;
                end
            end
            FETCH: begin
                if (relu) begin
                    rd_issue  = 1'b1;
                    state_nxt = WAIT;
                end else if (bus.ofifo_valid) begin
                    // Accumulate reads the old SRAM word alongside the pop; passthrough skips it.
                    pop       = 1'b1;
                    rd_issue  = !pass;
                    state_nxt = pass ? WRITE : WAIT;
                end
            end
            WAIT: begin
                state_nxt = WRITE;
            end
            WRITE: begin
                wr_issue  = 1'b1;
                state_nxt = (cnt_inc == cfg.length) ? DONE : FETCH;
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cfg       <= '0;
            ptr       <= '0;
            cnt       <= '0;
            ofifo_dat <= '0;
            sram_dat  <= '0;
        end else begin
            if (state == IDLE && bus.start) begin
                cfg.mode   <= bus.mode;
                cfg.length <= bus.length;
                ptr        <= bus.base_addr;
                cnt        <= '0;
            end
            if (pop) begin
                ofifo_dat <= bus.ofifo_out;
            end
            if (state == WAIT) begin
                sram_dat <= bus.sram_q;
            end
            if (wr_issue) begin
                ptr <= ptr + 1'b1;
                cnt <= cnt_inc;
            end
        end
    end

    // Each lane is an independent psum_bw-wide operation; sums wrap, never carry across lanes.
    for (genvar i = 0; i < col; i++) begin : g_lane
        logic [psum_bw-1:0] s_lane;
        logic [psum_bw-1:0] o_lane;
        logic [psum_bw-1:0] r_lane;

        assign s_lane = sram_dat[i*psum_bw +: psum_bw];
        assign o_lane = ofifo_dat[i*psum_bw +: psum_bw];

        always_comb begin
            r_lane = s_lane;
            if (relu) begin
                r_lane = s_lane[psum_bw-1] ? '0 : s_lane;
            end else if (pass) begin
                r_lane = o_lane;
            end else begin
                r_lane = s_lane + o_lane;
            end
        end

        assign result[i*psum_bw +: psum_bw] = r_lane;
    end

    assign bus.ofifo_rd  = pop;
    assign bus.sram_cen  = !(rd_issue || wr_issue);
    assign bus.sram_wen  = !wr_issue;
    assign bus.sram_addr = (rd_issue || wr_issue) ? ptr : '0;
    assign bus.sram_d    = wr_issue ? result : '0;
    assign bus.busy      = (state != IDLE);
    assign bus.done      = (state == DONE);
endmodule
